// File: rtl/fp_scoreboard.sv
// F-register issue scoreboard: per-register busy bits, in-flight count and
// decode stall generation for RAW/WAW/capacity hazards.

module fp_sb_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic set_i,
  input  logic clr_i,
  output logic busy_o
);
  logic busy_q, busy_d;

  // Set after clear so a same-cycle issue and writeback leave the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d = 1'b0;
    if (set_i) busy_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;
endmodule

module fp_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_valid,
  input  logic             dec_is_fpu,
  input  logic             dec_fp_reg_write,
  input  logic [4:0]       dec_rd,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic [4:0]       dec_rs3,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic             dec_use_rs3,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic             issue_ready,
  output logic             issue_fire,
  output logic [31:0]      busy_vec,
  output logic [CNT_W-1:0] inflight_cnt,
  output logic             sb_err,
  output logic [31:0]      stall_cnt
);
  localparam int NUM_REGS = 32;

  logic [NUM_REGS-1:0] busy_q, eff_busy, wb_hit, set_vec;
  logic [CNT_W-1:0]    cnt_q, cnt_d, post_cnt;
  logic [31:0]         stall_cnt_q, stall_cnt_d;
  logic                sb_err_q, sb_err_d;
  logic                fpu_req, raw, waw, cap, hazard;
  logic                wb_counted, issue_w, stall;

  genvar r;
  generate
    for (r = 0; r < NUM_REGS; r++) begin : g_reg
      assign wb_hit[r]  = wb_valid & (wb_rd == 5'(r));
      assign set_vec[r] = issue_w & (dec_rd == 5'(r));
      fp_sb_cell u_cell (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_i  (set_vec[r]),
        .clr_i  (wb_hit[r]),
        .busy_o (busy_q[r])
      );
    end
  endgenerate

  // A writeback landing this cycle is forwarded through the register file.
  assign eff_busy   = busy_q & ~wb_hit;
  assign wb_counted = wb_valid & busy_q[wb_rd];
  assign post_cnt   = cnt_q - CNT_W'(wb_counted);

  assign fpu_req = dec_valid & dec_is_fpu;
  assign raw     = (dec_use_rs1 & eff_busy[dec_rs1]) |
                   (dec_use_rs2 & eff_busy[dec_rs2]) |
                   (dec_use_rs3 & eff_busy[dec_rs3]);
  assign waw     = dec_fp_reg_write & eff_busy[dec_rd];
  assign cap     = dec_fp_reg_write & (post_cnt >= CNT_W'(MAX_INFLIGHT));
  assign hazard  = raw | waw | cap;

  assign issue_ready = rst_n & ~(fpu_req & hazard);
  assign issue_fire  = rst_n & fpu_req & ~hazard;
  assign stall       = rst_n & fpu_req & hazard;
  assign issue_w     = issue_fire & dec_fp_reg_write;

  always_comb begin
    cnt_d = cnt_q;
    if (issue_w & ~wb_counted)      cnt_d = cnt_q + CNT_W'(1);
    else if (~issue_w & wb_counted) cnt_d = cnt_q - CNT_W'(1);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  assign sb_err_d = sb_err_q | (wb_valid & ~busy_q[wb_rd]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      sb_err_q    <= sb_err_d;
    end
  end

  assign busy_vec     = busy_q;
  assign inflight_cnt = cnt_q;
  assign sb_err       = sb_err_q;
  assign stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_fp_scoreboard.sv
// Directed bench for fp_scoreboard with hand-computed expectations.

module tb_fp_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid, dec_is_fpu, dec_fp_reg_write;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2, dec_rs3;
  logic        dec_use_rs1, dec_use_rs2, dec_use_rs3;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        issue_ready, issue_fire, sb_err;
  logic [31:0] busy_vec, stall_cnt;
  logic [3:0]  inflight_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  fp_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_is_fpu(dec_is_fpu), .dec_fp_reg_write(dec_fp_reg_write),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs3(dec_rs3),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_use_rs3(dec_use_rs3),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue_ready(issue_ready), .issue_fire(issue_fire), .busy_vec(busy_vec),
    .inflight_cnt(inflight_cnt), .sb_err(sb_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are checked before the next one.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic fpw, input logic [4:0] rd,
                    input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rs3,
                    input logic u1, input logic u2, input logic u3);
    dec_valid = 1'b1; dec_is_fpu = 1'b1; dec_fp_reg_write = fpw;
    dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2; dec_rs3 = rs3;
    dec_use_rs1 = u1; dec_use_rs2 = u2; dec_use_rs3 = u3;
    #1;
  endtask

  task automatic idle();
    dec_valid = 1'b0; dec_is_fpu = 1'b0; dec_fp_reg_write = 1'b0;
    dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0; dec_rs3 = '0;
    dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_use_rs3 = 1'b0;
    wb_valid = 1'b0; wb_rd = '0;
    #1;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid = 1'b1; wb_rd = rd;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    chk("rst_ready_low", issue_ready, 0);
    step(); step();
    chk("rst_busy", busy_vec, 0);
    chk("rst_cnt", inflight_cnt, 0);
    chk("rst_err", sb_err, 0);
    chk("rst_stall", stall_cnt, 0);
    rst_n = 1'b1; #1;
    chk("idle_ready", issue_ready, 1);

    // Back-to-back RAW: FADD f3<-f1,f2 then FMUL f4<-f3,f5
    op(1, 3, 1, 2, 0, 1, 1, 0);
    chk("raw_fadd_fire", issue_fire, 1);
    step();
    chk("raw_busy", busy_vec, 32'h8);
    chk("raw_cnt", inflight_cnt, 1);
    op(1, 4, 3, 5, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("raw_stall_ready", issue_ready, 0);
      step();
    end
    wb(3);
    chk("raw_wb_ready", issue_ready, 1);
    chk("raw_wb_fire", issue_fire, 1);
    step();
    idle();
    chk("raw_stall_cnt", stall_cnt, 4);
    chk("raw_busy_after", busy_vec, 32'h10);
    chk("raw_cnt_after", inflight_cnt, 1);
    wb(4); step(); idle();
    chk("raw_drain_cnt", inflight_cnt, 0);

    // WAW with same-cycle writeback: FLW f7
    op(1, 7, 2, 0, 0, 1, 0, 0);
    step();
    chk("waw_busy7", busy_vec, 32'h80);
    chk("waw_waw_stall", issue_ready, 0);
    wb(7);
    chk("waw_wb_ready", issue_ready, 1);
    chk("waw_wb_fire", issue_fire, 1);
    step(); idle();
    chk("waw_busy_kept", busy_vec, 32'h80);
    chk("waw_cnt_same", inflight_cnt, 1);
    wb(7); step(); idle();
    chk("waw_drain", inflight_cnt, 0);

    // Capacity: f1..f4 fill the window, f5 stalls until f2 writes back
    for (int i = 1; i <= 4; i++) begin
      op(1, 5'(i), 0, 0, 0, 0, 0, 0);
      step();
    end
    chk("cap_cnt4", inflight_cnt, 4);
    chk("cap_busy", busy_vec, 32'h1E);
    op(1, 5, 0, 0, 0, 0, 0, 0);
    chk("cap_stall", issue_ready, 0);
    wb(2);
    chk("cap_wb_fire", issue_fire, 1);
    step(); idle();
    chk("cap_cnt_held", inflight_cnt, 4);
    chk("cap_busy2", busy_vec, 32'h3A);
    for (int r = 1; r <= 5; r++) begin
      if (r != 2) begin wb(5'(r)); step(); end
    end
    idle();
    chk("cap_drain", inflight_cnt, 0);
    chk("cap_err_clean", sb_err, 0);

    // rs3 hazard and FSW data dependency on f9
    op(1, 9, 0, 0, 0, 0, 0, 0);
    step();
    op(1, 10, 1, 2, 9, 1, 1, 1);
    chk("fma_rs3_stall", issue_ready, 0);
    op(1, 10, 1, 2, 9, 1, 1, 0);
    chk("fma_no_rs3_fire", issue_fire, 1);
    step();
    chk("fma_cnt", inflight_cnt, 2);
    op(0, 0, 3, 9, 0, 1, 1, 0);
    chk("fsw_stall", issue_ready, 0);
    step();
    chk("fsw_stall_cnt", stall_cnt, 5);
    wb(9); step();
    wb_valid = 1'b0; #1;
    chk("fsw_fire", issue_fire, 1);
    step(); idle();
    chk("fsw_cnt_same", inflight_cnt, 1);
    chk("fsw_busy", busy_vec, 32'h400);
    wb(10); step(); idle();

    // Spurious writeback sets sticky error
    wb(12); step(); idle();
    chk("spur_err", sb_err, 1);
    chk("spur_cnt", inflight_cnt, 0);
    step();
    chk("spur_sticky", sb_err, 1);

    // Reset mid-operation
    for (int i = 1; i <= 3; i++) begin
      op(1, 5'(i), 0, 0, 0, 0, 0, 0);
      step();
    end
    idle();
    chk("mid_cnt3", inflight_cnt, 3);
    rst_n = 1'b0;
    op(1, 6, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_ready", issue_ready, 0);
    chk("mid_rst_fire", issue_fire, 0);
    step();
    rst_n = 1'b1;
    idle();
    chk("mid_busy", busy_vec, 0);
    chk("mid_cnt", inflight_cnt, 0);
    chk("mid_stall", stall_cnt, 0);
    chk("mid_err", sb_err, 0);
    op(1, 4, 1, 0, 0, 1, 0, 0);
    chk("mid_dep_fire", issue_fire, 1);
    step(); idle();
    chk("mid_dep_cnt", inflight_cnt, 1);
    dec_valid = 1'b1; dec_rs1 = 5'd4; dec_use_rs1 = 1'b1; #1;
    chk("nonfpu_ready", issue_ready, 1);
    chk("nonfpu_fire", issue_fire, 0);
    idle();
    wb(1); step(); idle();
    chk("mid_stale_wb_err", sb_err, 1);
    chk("mid_stale_cnt", inflight_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
